seg_s2p_receiver: RTL and testbench

- Serial-to-parallel receiver for the 4-wire segment shift interface (SEGCLK, SEGDT, SEGEN, SEGCLR) that the display path drives.
- Oversamples the four wires on the system clock and reassembles each WIDTH-bit frame into a parallel word.
- Reports frame completion and protocol errors.
- Used as a loopback monitor/checker on the display link and as the input end for board-to-board pattern transfer.

---
 rtl/seg_s2p_receiver_pkg.sv | 17 +
 rtl/seg_s2p_receiver_sync_edge.sv | 38 +++
 rtl/seg_s2p_receiver.sv | 144 ++++++++++++++
 tb/tb_seg_s2p_receiver.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/seg_s2p_receiver_pkg.sv
// Shared definitions for the segment shift link: state encoding, idle line
// levels and the default frame width used by both link ends.
package seg_s2p_receiver_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_SEGCLK = 1'b0;
  localparam logic IDLE_SEGDT  = 1'b0;
  localparam logic IDLE_SEGEN  = 1'b1;
  localparam logic IDLE_SEGCLR = 1'b1;

  localparam int unsigned SEG_FRAME_WIDTH = 64;

endpackage

// File: rtl/seg_s2p_receiver_sync_edge.sv
// N-stage synchronizer with registered rise/fall detect; level_o is aligned
// with the edge pulses so data can be sampled coherently with a clock edge.
module seg_s2p_receiver_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~hist_q;
      fall_q <= ~sync_q[STAGES-1] & hist_q;
    end
  end

  assign level_o = hist_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/seg_s2p_receiver.sv
// Serial-to-parallel receiver for the 4-wire segment shift link: rebuilds
// WIDTH-bit frames and flags short, long and stalled frames.
module seg_s2p_receiver
  import seg_s2p_receiver_pkg::*;
#(
  parameter int unsigned WIDTH       = SEG_FRAME_WIDTH,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       SEGCLK,
  input  logic                       SEGDT,
  input  logic                       SEGEN,
  input  logic                       SEGCLR,
  output logic [WIDTH-1:0]           data,
  output logic                       data_valid,
  output logic                       frame_err,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
  output logic                       busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic clk_lvl, clk_rise, clk_fall;
  logic dt_lvl, dt_rise, dt_fall;
  logic en_lvl, en_rise, en_fall;
  logic clr_lvl, clr_rise, clr_fall;
  logic unused_sync;

  seg_s2p_receiver_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(IDLE_SEGCLK)) u_sync_clk (
    .clk(clk), .rst(rst), .d_i(SEGCLK), .level_o(clk_lvl), .rise_o(clk_rise), .fall_o(clk_fall)
  );
  seg_s2p_receiver_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(IDLE_SEGDT)) u_sync_dt (
    .clk(clk), .rst(rst), .d_i(SEGDT), .level_o(dt_lvl), .rise_o(dt_rise), .fall_o(dt_fall)
  );
  seg_s2p_receiver_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(IDLE_SEGEN)) u_sync_en (
    .clk(clk), .rst(rst), .d_i(SEGEN), .level_o(en_lvl), .rise_o(en_rise), .fall_o(en_fall)
  );
  seg_s2p_receiver_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(IDLE_SEGCLR)) u_sync_clr (
    .clk(clk), .rst(rst), .d_i(SEGCLR), .level_o(clr_lvl), .rise_o(clr_rise), .fall_o(clr_fall)
  );

  assign unused_sync = ^{clk_lvl, clk_fall, dt_rise, dt_fall, en_lvl, en_fall, clr_rise, clr_fall};

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TW-1:0]     to_q, to_d;
  logic              ovf_q, ovf_d;
  logic              pend_ok_q, pend_ok_d;
  logic              pend_err_q, pend_err_d;
  logic              dv_q, fe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      ovf_q      <= 1'b0;
      pend_ok_q  <= 1'b0;
      pend_err_q <= 1'b0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      ovf_q      <= ovf_d;
      pend_ok_q  <= pend_ok_d;
      pend_err_q <= pend_err_d;
      dv_q       <= pend_ok_q;
      fe_q       <= pend_err_q;
    end
  end

  // Event priority: clear level > frame end > timeout > shift clock.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    ovf_d      = ovf_q;
    pend_ok_d  = 1'b0;
    pend_err_d = 1'b0;

    if (!clr_lvl) begin
      state_d = ST_IDLE;
      shift_d = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      to_d    = '0;
    end else if (en_rise) begin
      // A shift clock coinciding with the frame end is dropped here.
      if (state_q == ST_SHIFT) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        to_d    = '0;
        if (cnt_q == CW'(WIDTH) && !ovf_q) begin
          data_d    = shift_q;
          pend_ok_d = 1'b1;
        end else begin
          pend_err_d = 1'b1;
        end
      end
    end else if (state_q == ST_SHIFT && to_q == TW'(TIMEOUT - 1)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      ovf_d      = 1'b0;
      to_d       = '0;
      pend_err_d = 1'b1;
    end else if (clk_rise) begin
      to_d = '0;
      if (state_q == ST_IDLE) begin
        state_d = ST_SHIFT;
        shift_d = WIDTH'(dt_lvl);
        cnt_d   = CW'(1);
        ovf_d   = 1'b0;
      end else if (cnt_q == CW'(WIDTH)) begin
        ovf_d = 1'b1;
      end else begin
        shift_d = {shift_q[WIDTH-2:0], dt_lvl};
        cnt_d   = cnt_q + CW'(1);
      end
    end else if (state_q == ST_SHIFT) begin
      to_d = to_q + TW'(1);
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign bit_cnt    = cnt_q;
  assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_seg_s2p_receiver.sv
// Directed bench for seg_s2p_receiver: good, short, long, cleared, stalled
// and reset-interrupted frames with hand-computed expectations.
module tb_seg_s2p_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SEGCLK = 1'b0;
  logic        SEGDT = 1'b0;
  logic        SEGEN = 1'b1;
  logic        SEGCLR = 1'b1;
  logic [63:0] data;
  logic        data_valid;
  logic        frame_err;
  logic [6:0]  bit_cnt;
  logic        busy;

  int n_chk = 0;
  int n_err = 0;
  int fe_tot = 0;
  int dv_tot = 0;

  localparam logic [63:0] FRAME_A = 64'h9E9E9E9E_C58FC58F;
  localparam logic [63:0] FRAME_C = 64'h01234567_89ABCDEF;
  localparam logic [63:0] FRAME_L = 64'hAAAA5555_0F0F1234;
  localparam logic [63:0] FRAME_P = 64'h13579BDF_2468ACE0;
  localparam logic [63:0] FRAME_Q = 64'hFEDCBA98_76543210;

  seg_s2p_receiver dut (
    .clk(clk), .rst(rst), .SEGCLK(SEGCLK), .SEGDT(SEGDT), .SEGEN(SEGEN), .SEGCLR(SEGCLR),
    .data(data), .data_valid(data_valid), .frame_err(frame_err), .bit_cnt(bit_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_tot++;
    if (data_valid) dv_tot++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SEGDT = w[i];
      tick(4);
      SEGCLK = 1'b1;
      tick(4);
      SEGCLK = 1'b0;
      tick(4);
    end
  endtask

  task automatic start_frame();
    SEGEN = 1'b0;
    tick(4);
  endtask

  // Raise SEGEN and watch a fixed window for result pulses.
  task automatic end_frame(output int dv_at, output int fe_at, output int dv_n, output int fe_n);
    dv_at = -1; fe_at = -1; dv_n = 0; fe_n = 0;
    SEGEN = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (data_valid) begin dv_n++; dv_at = k; end
      if (frame_err)  begin fe_n++; fe_at = k; end
    end
  endtask

  initial begin
    int dv_at, fe_at, dv_n, fe_n, fe0, dv0, wait_cyc;

    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_data", data, 64'd0);
    check("rst_dv", 64'(data_valid), 64'd0);
    check("rst_fe", 64'(frame_err), 64'd0);
    check("rst_cnt", 64'(bit_cnt), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // Full good frame
    start_frame();
    send_bits(FRAME_A, 64);
    check("full_cnt", 64'(bit_cnt), 64'd64);
    check("full_busy", 64'(busy), 64'd1);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("full_dv_n", 64'(dv_n), 64'd1);
    check("full_dv_lat", 64'(dv_at), 64'd5);
    check("full_fe_n", 64'(fe_n), 64'd0);
    check("full_data", data, FRAME_A);
    check("full_cnt0", 64'(bit_cnt), 64'd0);
    check("full_busy0", 64'(busy), 64'd0);

    // Short frame
    start_frame();
    send_bits(64'h00000000_FFFFFFFF, 32);
    check("short_cnt", 64'(bit_cnt), 64'd32);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("short_fe_n", 64'(fe_n), 64'd1);
    check("short_fe_lat", 64'(fe_at), 64'd5);
    check("short_dv_n", 64'(dv_n), 64'd0);
    check("short_data", data, FRAME_A);
    check("short_cnt0", 64'(bit_cnt), 64'd0);

    // Long frame: 65 bits, counter saturates at 64
    start_frame();
    send_bits(FRAME_L, 64);
    send_bits(64'd1, 1);
    check("long_cnt", 64'(bit_cnt), 64'd64);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("long_fe_n", 64'(fe_n), 64'd1);
    check("long_dv_n", 64'(dv_n), 64'd0);
    check("long_data", data, FRAME_A);

    // Clear mid-frame, then a full frame
    fe0 = fe_tot; dv0 = dv_tot;
    start_frame();
    send_bits(64'h00000000_000ABCDE, 20);
    check("clr_cnt20", 64'(bit_cnt), 64'd20);
    SEGCLR = 1'b0;
    tick(5);
    check("clr_cnt0", 64'(bit_cnt), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_data", data, FRAME_A);
    SEGCLR = 1'b1;
    tick(4);
    check("clr_no_fe", 64'(fe_tot - fe0), 64'd0);
    check("clr_no_dv", 64'(dv_tot - dv0), 64'd0);
    send_bits(FRAME_C, 64);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("clr_dv_n", 64'(dv_n), 64'd1);
    check("clr_fe_n", 64'(fe_n), 64'd0);
    check("clr_final", data, FRAME_C);

    // Timeout after 10 bits
    fe0 = fe_tot;
    start_frame();
    send_bits(64'h00000000_000002B5, 10);
    check("to_busy1", 64'(busy), 64'd1);
    wait_cyc = -1;
    for (int k = 1; k <= 1200 && wait_cyc < 0; k++) begin
      tick(1);
      if (frame_err) wait_cyc = k;
    end
    check("to_seen", 64'(wait_cyc >= 0), 64'd1);
    check("to_window", 64'(wait_cyc >= 1016 && wait_cyc <= 1026), 64'd1);
    check("to_busy0", 64'(busy), 64'd0);
    check("to_cnt0", 64'(bit_cnt), 64'd0);
    tick(1);
    check("to_one_pulse", 64'(fe_tot - fe0), 64'd1);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("to_en_fe", 64'(fe_n), 64'd0);
    check("to_en_dv", 64'(dv_n), 64'd0);
    check("to_data", data, FRAME_C);

    // Reset at bit 40, then two frames back to back
    fe0 = fe_tot;
    start_frame();
    send_bits(FRAME_Q, 40);
    check("mr_cnt40", 64'(bit_cnt), 64'd40);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mr_data", data, 64'd0);
    check("mr_cnt", 64'(bit_cnt), 64'd0);
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_dv", 64'(data_valid), 64'd0);
    check("mr_fe", 64'(frame_err), 64'd0);
    start_frame();
    send_bits(FRAME_P, 64);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("bb_a_dv", 64'(dv_n), 64'd1);
    check("bb_a_data", data, FRAME_P);
    start_frame();
    send_bits(FRAME_Q, 64);
    end_frame(dv_at, fe_at, dv_n, fe_n);
    check("bb_b_dv", 64'(dv_n), 64'd1);
    check("bb_b_data", data, FRAME_Q);
    check("mr_no_fe", 64'(fe_tot - fe0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
